// File: rtl/mips_fwd_scoreboard.sv
// N-issue result scoreboard and operand forwarding between ID and EX.
// Tracks in-flight writes in EX/MA/WB, forwards the youngest result, raises load-use stall and splits dependent bundles.
module mips_fwd_scoreboard #(
   parameter int LANES  = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         hang,
   input  logic [LANES-1:0]             kill_ex,
   input  logic [LANES-1:0]             iss_valid,
   input  logic [LANES-1:0]             iss_we,
   input  logic [LANES-1:0]             iss_load,
   input  logic [LANES*ADDR_W-1:0]      iss_waddr,
   input  logic [2*LANES*ADDR_W-1:0]    src_addr,
   input  logic [2*LANES*DATA_W-1:0]    rf_data,
   input  logic [LANES*DATA_W-1:0]      ex_data,
   input  logic [LANES*DATA_W-1:0]      ma_data,
   input  logic [LANES*DATA_W-1:0]      wb_data,
   output logic [2*LANES*DATA_W-1:0]    opnd_data,
   output logic [2*LANES-1:0]           fwd_hit,
   output logic                         stall,
   output logic [LANES-1:0]             iss_accept
);

   localparam int NSRC = 2 * LANES;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic              load;
      logic [ADDR_W-1:0] waddr;
   } entry_t;

   entry_t [LANES-1:0] ex_q;
   entry_t [LANES-1:0] ma_q;
   entry_t [LANES-1:0] wb_q;

   logic             load_use;
   logic [LANES-1:0] dep;
   int               first_dep;

   function automatic logic hit(input entry_t e, input logic [ADDR_W-1:0] src);
      return e.valid && e.we && (e.waddr == src) && (src != '0);
   endfunction

   always_comb begin
      opnd_data  = rf_data;
      fwd_hit    = '0;
      load_use   = 1'b0;
      dep        = '0;
      first_dep  = LANES;
      iss_accept = '0;
      stall      = 1'b0;

      // Oldest first so that each later, younger match overwrites the previous one.
      for (int s = 0; s < NSRC; s++) begin
         for (int k = 0; k < LANES; k++) begin
            if (hit(wb_q[k], src_addr[s*ADDR_W +: ADDR_W])) begin
               opnd_data[s*DATA_W +: DATA_W] = wb_data[k*DATA_W +: DATA_W];
               fwd_hit[s] = 1'b1;
            end
         end
         for (int k = 0; k < LANES; k++) begin
            if (hit(ma_q[k], src_addr[s*ADDR_W +: ADDR_W])) begin
               opnd_data[s*DATA_W +: DATA_W] = ma_data[k*DATA_W +: DATA_W];
               fwd_hit[s] = 1'b1;
            end
         end
         for (int k = 0; k < LANES; k++) begin
            if (hit(ex_q[k], src_addr[s*ADDR_W +: ADDR_W]) && !kill_ex[k]) begin
               opnd_data[s*DATA_W +: DATA_W] = ex_data[k*DATA_W +: DATA_W];
               fwd_hit[s] = 1'b1;
               if (ex_q[k].load && iss_valid[s/2])
                  load_use = 1'b1;
            end
         end
      end

      for (int j = 1; j < LANES; j++) begin
         for (int i = 0; i < j; i++) begin
            for (int b = 0; b < 2; b++) begin
               if (iss_valid[i] && iss_we[i] &&
                   (iss_waddr[i*ADDR_W +: ADDR_W] == src_addr[(2*j+b)*ADDR_W +: ADDR_W]) &&
                   (src_addr[(2*j+b)*ADDR_W +: ADDR_W] != '0))
                  dep[j] = 1'b1;
            end
         end
      end

      for (int j = LANES - 1; j >= 0; j--) begin
         if (dep[j])
            first_dep = j;
      end

      for (int k = 0; k < LANES; k++)
         iss_accept[k] = iss_valid[k] && (k < first_dep) && !load_use && !hang;

      stall = load_use;

      if (RST) begin
         opnd_data  = rf_data;
         fwd_hit    = '0;
         stall      = 1'b0;
         iss_accept = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ex_q <= '0;
         ma_q <= '0;
         wb_q <= '0;
      end else if (!hang) begin
         wb_q <= ma_q;
         for (int k = 0; k < LANES; k++) begin
            ma_q[k].valid <= ex_q[k].valid & ~kill_ex[k];
            ma_q[k].we    <= ex_q[k].we;
            ma_q[k].load  <= ex_q[k].load;
            ma_q[k].waddr <= ex_q[k].waddr;
            // A non-accepted lane enters as a bubble.
            ex_q[k].valid <= iss_accept[k];
            ex_q[k].we    <= iss_we[k];
            ex_q[k].load  <= iss_load[k];
            ex_q[k].waddr <= iss_waddr[k*ADDR_W +: ADDR_W];
         end
      end
   end

endmodule

// File: tb/tb_mips_fwd_scoreboard.sv
// Directed testbench for mips_fwd_scoreboard (2 lanes): forwarding priority, load-use, bundle split, hang, kill.
module tb_mips_fwd_scoreboard;

   localparam int LANES  = 2;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic                      CLK;
   logic                      RST;
   logic                      hang;
   logic [LANES-1:0]          kill_ex;
   logic [LANES-1:0]          iss_valid;
   logic [LANES-1:0]          iss_we;
   logic [LANES-1:0]          iss_load;
   logic [LANES*ADDR_W-1:0]   iss_waddr;
   logic [2*LANES*ADDR_W-1:0] src_addr;
   logic [2*LANES*DATA_W-1:0] rf_data;
   logic [LANES*DATA_W-1:0]   ex_data;
   logic [LANES*DATA_W-1:0]   ma_data;
   logic [LANES*DATA_W-1:0]   wb_data;
   logic [2*LANES*DATA_W-1:0] opnd_data;
   logic [2*LANES-1:0]        fwd_hit;
   logic                      stall;
   logic [LANES-1:0]          iss_accept;

   int n_checks = 0;
   int n_errors = 0;

   mips_fwd_scoreboard #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RST(RST), .hang(hang), .kill_ex(kill_ex),
      .iss_valid(iss_valid), .iss_we(iss_we), .iss_load(iss_load), .iss_waddr(iss_waddr),
      .src_addr(src_addr), .rf_data(rf_data), .ex_data(ex_data), .ma_data(ma_data),
      .wb_data(wb_data), .opnd_data(opnd_data), .fwd_hit(fwd_hit), .stall(stall),
      .iss_accept(iss_accept)
   );

   // Clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drivers
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      hang      = 1'b0;
      kill_ex   = '0;
      iss_valid = '0;
      iss_we    = '0;
      iss_load  = '0;
      iss_waddr = '0;
      src_addr  = '0;
   endtask

   task automatic set_lane(input int k, input logic v, input logic we, input logic ld,
                           input logic [4:0] wa, input logic [4:0] s0, input logic [4:0] s1);
      iss_valid[k] = v;
      iss_we[k]    = we;
      iss_load[k]  = ld;
      iss_waddr[k*ADDR_W +: ADDR_W]       = wa;
      src_addr[(2*k)*ADDR_W +: ADDR_W]    = s0;
      src_addr[(2*k+1)*ADDR_W +: ADDR_W]  = s1;
   endtask

   task automatic default_data();
      for (int s = 0; s < 2*LANES; s++)
         rf_data[s*DATA_W +: DATA_W] = 32'hF000_0000 + s;
      ex_data = {32'hE000_0001, 32'hE000_0000};
      ma_data = {32'hA000_0001, 32'hA000_0000};
      wb_data = {32'hB000_0001, 32'hB000_0000};
   endtask

   function automatic logic [31:0] opnd(input int s);
      return opnd_data[s*DATA_W +: DATA_W];
   endfunction

   function automatic logic [31:0] rfv(input int s);
      return rf_data[s*DATA_W +: DATA_W];
   endfunction

   initial begin
      idle();
      default_data();

      // Reset with a busy-looking bundle on the inputs
      RST = 1'b1;
      set_lane(0, 1, 1, 0, 5'd5, 5'd1, 5'd2);
      set_lane(1, 1, 1, 0, 5'd6, 5'd5, 5'd3);
      settle();
      check("rst_stall", stall, 0);
      check("rst_accept", iss_accept, 2'b00);
      check("rst_fwd_hit", fwd_hit, 4'b0000);
      check("rst_opnd", opnd_data, rf_data);
      tick();
      tick();
      RST = 1'b0;
      idle();
      src_addr = {5'd4, 5'd3, 5'd2, 5'd1};
      settle();
      check("post_rst_fwd_hit", fwd_hit, 4'b0000);
      check("post_rst_opnd", opnd_data, rf_data);

      // Back-to-back ALU: lane0 writes r5
      set_lane(0, 1, 1, 0, 5'd5, 5'd1, 5'd2);
      settle();
      check("alu_issue_accept", iss_accept, 2'b01);
      check("alu_issue_hit", fwd_hit, 4'b0000);
      tick();
      idle();
      set_lane(1, 1, 0, 0, 5'd0, 5'd5, 5'd0);
      ex_data[31:0] = 32'h0000_1234;
      settle();
      check("alu_ex_opnd", opnd(2), 32'h0000_1234);
      check("alu_ex_hit", fwd_hit, 4'b0100);
      check("alu_ex_accept", iss_accept, 2'b10);
      tick();
      ex_data[31:0] = 32'h0000_DEAD;
      ma_data[31:0] = 32'h0000_5678;
      settle();
      check("alu_ma_opnd", opnd(2), 32'h0000_5678);
      check("alu_ma_hit", fwd_hit, 4'b0100);
      tick();
      wb_data[31:0] = 32'h0000_9ABC;
      settle();
      check("alu_wb_opnd", opnd(2), 32'h0000_9ABC);
      tick();
      settle();
      check("alu_rf_opnd", opnd(2), rfv(2));
      check("alu_rf_hit", fwd_hit, 4'b0000);
      default_data();

      // Priority: EX[1] and MA[0] both hold r7; MA[1] writes r0
      idle();
      set_lane(0, 1, 1, 0, 5'd7, 5'd0, 5'd0);
      set_lane(1, 1, 1, 0, 5'd0, 5'd0, 5'd0);
      settle();
      check("prio_a_accept", iss_accept, 2'b11);
      tick();
      idle();
      set_lane(1, 1, 1, 0, 5'd7, 5'd0, 5'd0);
      settle();
      check("prio_b_accept", iss_accept, 2'b10);
      tick();
      idle();
      set_lane(0, 1, 0, 0, 5'd0, 5'd7, 5'd0);
      ex_data = {32'h0000_AAAA, 32'h0000_1111};
      ma_data = {32'h0000_2222, 32'h0000_BBBB};
      rf_data[1*DATA_W +: DATA_W] = 32'h0;
      settle();
      check("prio_ex_over_ma", opnd(0), 32'h0000_AAAA);
      check("prio_r0_opnd", opnd(1), 32'h0);
      check("prio_hit", fwd_hit, 4'b0001);
      tick();
      idle();
      set_lane(0, 0, 0, 0, 5'd0, 5'd7, 5'd0);
      settle();
      check("prio_ma_over_wb", opnd(0), 32'h0000_2222);
      default_data();
      tick();
      tick();
      tick();

      // Load-use: lw r3 in lane0, then use r3
      idle();
      set_lane(0, 1, 1, 1, 5'd3, 5'd0, 5'd0);
      settle();
      check("lu_issue_accept", iss_accept, 2'b01);
      tick();
      idle();
      set_lane(0, 1, 1, 0, 5'd10, 5'd3, 5'd0);
      settle();
      check("lu_stall", stall, 1);
      check("lu_accept", iss_accept, 2'b00);
      tick();
      ma_data[31:0] = 32'h0000_3333;
      settle();
      check("lu_release_stall", stall, 0);
      check("lu_release_accept", iss_accept, 2'b01);
      check("lu_ma_opnd", opnd(0), 32'h0000_3333);
      tick();
      default_data();

      // Intra-bundle split: lane0 writes r9, lane1 reads r9
      idle();
      set_lane(0, 1, 1, 0, 5'd9, 5'd0, 5'd0);
      set_lane(1, 1, 1, 0, 5'd11, 5'd9, 5'd0);
      settle();
      check("split_accept", iss_accept, 2'b01);
      check("split_stall", stall, 0);
      tick();
      idle();
      set_lane(0, 1, 1, 0, 5'd11, 5'd9, 5'd0);
      ex_data[31:0] = 32'h0000_9999;
      settle();
      check("split_fwd", opnd(0), 32'h0000_9999);
      check("split_re_accept", iss_accept, 2'b01);
      tick();
      default_data();

      // Stall together with an intra-bundle dependency
      idle();
      set_lane(0, 1, 1, 1, 5'd12, 5'd0, 5'd0);
      tick();
      idle();
      set_lane(0, 1, 1, 0, 5'd13, 5'd12, 5'd0);
      set_lane(1, 1, 1, 0, 5'd14, 5'd13, 5'd0);
      settle();
      check("stall_dep_stall", stall, 1);
      check("stall_dep_accept", iss_accept, 2'b00);
      tick();
      settle();
      check("stall_dep_after", iss_accept, 2'b01);
      tick();
      idle();
      tick();
      tick();
      tick();

      // Hang: EX entry for r5 stays put for three edges
      set_lane(0, 1, 1, 0, 5'd5, 5'd0, 5'd0);
      tick();
      idle();
      hang = 1'b1;
      set_lane(1, 1, 1, 0, 5'd20, 5'd5, 5'd0);
      ex_data[31:0] = 32'h0000_5555;
      for (int c = 0; c < 3; c++) begin
         settle();
         check("hang_opnd", opnd(2), 32'h0000_5555);
         check("hang_accept", iss_accept, 2'b00);
         tick();
      end
      hang = 1'b0;
      iss_valid = '0;
      settle();
      check("hang_release_opnd", opnd(2), 32'h0000_5555);
      tick();
      default_data();

      // Kill: EX[1] load of r4 killed, r4 falls to MA[0]; MA[1] stays invalid
      idle();
      set_lane(0, 1, 1, 0, 5'd4, 5'd0, 5'd0);
      tick();
      idle();
      set_lane(1, 1, 1, 1, 5'd4, 5'd0, 5'd0);
      tick();
      idle();
      kill_ex = 2'b10;
      set_lane(0, 1, 0, 0, 5'd0, 5'd4, 5'd0);
      ex_data = {32'h000A_AAA4, 32'h0000_0E00};
      ma_data = {32'h0000_1BAD, 32'h0000_4444};
      wb_data = {32'h0000_2BAD, 32'h0000_0440};
      settle();
      check("kill_fallthrough", opnd(0), 32'h0000_4444);
      check("kill_no_stall", stall, 0);
      check("kill_accept", iss_accept, 2'b01);
      tick();
      kill_ex = 2'b00;
      settle();
      check("kill_ma1_invalid", opnd(0), 32'h0000_0440);
      check("kill_hit", fwd_hit, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      n_errors++;
      $display("FAIL timeout: got=running expected=finished");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1);
   end

endmodule
